// File: rtl/seqdet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seqdet_pkg
//  Description : Shared constants, types and helpers for the programmable
//                serial pattern detector.
//                  OVL_ON / OVL_OFF : values of the overlap select input
//                  len_t            : pattern-length type for the default
//                                     maximum pattern length
//                  len_mask()       : low-len-bits mask, LEN_MASK_W wide
//  Revision    : 1.0 - initial release
// ============================================================================
package seqdet_pkg;

   localparam logic OVL_ON  = 1'b1;
   localparam logic OVL_OFF = 1'b0;

   localparam int SEQDET_MAX_LEN = 8;
   typedef logic [$clog2(SEQDET_MAX_LEN+1)-1:0] len_t;

   // Mask width is fixed so that one function serves every MAX_LEN up to 63.
   // Callers zero-extend their operand to this width.
   localparam int LEN_MASK_W = 64;

   function automatic logic [LEN_MASK_W-1:0] len_mask(input int unsigned len);
      logic [LEN_MASK_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < LEN_MASK_W; i++) begin
         if (i < len) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seqdet_hist.sv
`default_nettype none
// ============================================================================
//  Module      : seqdet_hist
//  Description : Bit history shift register with saturating fill counter.
//                Presents the would-be next history/fill so the parent can
//                evaluate a match on the edge that samples the bit.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                clr_i      - clear history and fill (pattern reload)
//                valid_i    - bit_i is sampled this edge
//                bit_i      - serial data bit
//                restart_i  - zero the fill count (non-overlapping match)
//                hist_n_o   - history including bit_i, newest bit at [0]
//                fill_n_o   - fill count including bit_i, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module seqdet_hist #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN+1)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_i,
   input  logic               valid_i,
   input  logic               bit_i,
   input  logic               restart_i,
   output logic [MAX_LEN-1:0] hist_n_o,
   output logic [LEN_W-1:0]   fill_n_o
);

   // The oldest of MAX_LEN history bits is only ever shifted out, so one
   // fewer bit is stored; hist_n_o still spans the full MAX_LEN window.
   logic [MAX_LEN-2:0] hist_q;
   logic [LEN_W-1:0]   fill_q;

   assign hist_n_o = {hist_q, bit_i};
   assign fill_n_o = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (valid_i) begin
         hist_q <= hist_n_o[MAX_LEN-2:0];
         fill_q <= restart_i ? '0 : fill_n_o;
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_detector_prog.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_prog
//  Description : Runtime-programmable serial bit-pattern detector with input
//                qualifier, overlapping/non-overlapping detection and a
//                registered one-cycle match pulse.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                x_valid, x   - qualified serial input
//                overlap      - 1 overlapping, 0 non-overlapping detection
//                cfg_load     - load cfg_pattern / cfg_len (clears history)
//                cfg_pattern  - right-aligned pattern, [len-1] received first
//                cfg_len      - pattern length, clamped to MAX_LEN, 0 = off
//                cnt_clr      - clear match counter
//                y            - registered match pulse
//                match_cnt    - saturating match count
//  Config      : SEQDET_COUNT_EN - when defined, match_cnt port and counter
//                exist; otherwise cnt_clr is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_prog
   import seqdet_pkg::*;
#(
   parameter int                 MAX_LEN     = 8,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0011_1010,
   parameter int                 DEF_LEN     = 6,
   parameter int                 CNT_W       = 8
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           x_valid,
   input  logic                           x,
   input  logic                           overlap,
   input  logic                           cfg_load,
   input  logic [MAX_LEN-1:0]             cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
   input  logic                           cnt_clr,
   output logic                           y
`ifdef SEQDET_COUNT_EN
   ,
   output logic [CNT_W-1:0]               match_cnt
`endif
);

   localparam int LEN_W = $clog2(MAX_LEN+1);

   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               y_q;

   logic [MAX_LEN-1:0] w_hist_n;
   logic [LEN_W-1:0]   w_fill_n;
   logic [LEN_W-1:0]   w_cfg_len_clamped;
   logic               w_match;

   assign w_cfg_len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

   // A load on the same edge discards the bit, so it can never match.
   assign w_match = x_valid && !cfg_load && (len_q != '0) && (w_fill_n >= len_q) &&
                    ((LEN_MASK_W'(w_hist_n ^ pat_q) & len_mask(32'(len_q))) == '0);

   seqdet_hist #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_hist (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (cfg_load),
      .valid_i   (x_valid),
      .bit_i     (x),
      .restart_i (w_match && (overlap == OVL_OFF)),
      .hist_n_o  (w_hist_n),
      .fill_n_o  (w_fill_n)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q <= DEF_PATTERN;
         len_q <= LEN_W'(DEF_LEN);
         y_q   <= 1'b0;
      end else if (cfg_load) begin
         pat_q <= cfg_pattern;
         len_q <= w_cfg_len_clamped;
         y_q   <= 1'b0;
      end else begin
         y_q   <= w_match;
      end
   end

   assign y = y_q;

`ifdef SEQDET_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   // A clear coinciding with a match restarts the count at one.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= w_match ? CNT_W'(1) : '0;
      end else if (w_match && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign match_cnt = cnt_q;
`else
   logic w_unused_cnt;
   assign w_unused_cnt = cnt_clr & (CNT_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector_prog
//  Description : Directed self-checking bench for seq_detector_prog.
//                Counter checks are present only with SEQDET_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_prog;

   logic       clk;
   logic       rst;
   logic       x_valid;
   logic       x;
   logic       overlap;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cnt_clr;
   logic       y;
`ifdef SEQDET_COUNT_EN
   logic [3:0] match_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   seq_detector_prog #(
      .MAX_LEN     (8),
      .DEF_PATTERN (8'b0011_1010),
      .DEF_LEN     (6),
      .CNT_W       (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .x_valid     (x_valid),
      .x           (x),
      .overlap     (overlap),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cnt_clr     (cnt_clr),
      .y           (y)
`ifdef SEQDET_COUNT_EN
      ,
      .match_cnt   (match_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: apply the bit, clock it in, check y just after the edge,
   // then drop all one-shot controls.
   task automatic step(input logic v, input logic b, input logic exp_y, input string tag);
      x_valid = v;
      x       = b;
      @(posedge clk);
      #1;
      check(tag, {31'd0, y}, {31'd0, exp_y});
      x_valid  = 1'b0;
      x        = 1'b0;
      cfg_load = 1'b0;
      cnt_clr  = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l, input logic clr);
      cfg_load    = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      cnt_clr     = clr;
      step(1'b0, 1'b0, 1'b0, "load_y");
   endtask

   task automatic send6(input logic [5:0] bits, input logic [5:0] exp, input string tag);
      for (int i = 5; i >= 0; i--) step(1'b1, bits[i], exp[i], tag);
   endtask

   initial begin
      rst = 1'b1; x_valid = 1'b0; x = 1'b0; overlap = 1'b1;
      cfg_load = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0; cnt_clr = 1'b0;

      // Reset state
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0, "reset_y");
`ifdef SEQDET_COUNT_EN
      check("reset_cnt", {28'd0, match_cnt}, 32'd0);
`endif

      // Default pattern 111010
      send6(6'b111010, 6'b000001, "def_stream");
      step(1'b0, 1'b0, 1'b0, "def_after");
`ifdef SEQDET_COUNT_EN
      check("def_cnt", {28'd0, match_cnt}, 32'd1);
`endif

      // Pattern 1010 overlapping: pulses after bits 4 and 6
      overlap = 1'b1;
      load(8'b0000_1010, 4'd4, 1'b1);
      send6(6'b101010, 6'b000101, "ovl_stream");
`ifdef SEQDET_COUNT_EN
      check("ovl_cnt", {28'd0, match_cnt}, 32'd2);
`endif

      // Non-overlapping: pulse after bit 4 only, next needs 4 fresh bits
      overlap = 1'b0;
      load(8'b0000_1010, 4'd4, 1'b0);
      send6(6'b101010, 6'b000100, "novl_stream");
      step(1'b1, 1'b1, 1'b0, "novl_b7");
      step(1'b1, 1'b0, 1'b1, "novl_b8");
      overlap = 1'b1;

      // Gaps of 3 invalid cycles between every bit of 111010
      load(8'b0011_1010, 4'd6, 1'b0);
      begin
         logic [5:0] gb;
         gb = 6'b111010;
         for (int i = 5; i >= 0; i--) begin
            step(1'b1, gb[i], (i == 0), "gap_bit");
            for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 1'b0, "gap_idle");
         end
      end

      // Reset mid-pattern; a load on the reset edge loses to the reset
      load(8'b0011_1010, 4'd6, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, (i != 3), 1'b0, "rstmid_pre");
      rst = 1'b1;
      cfg_load = 1'b1; cfg_pattern = 8'b0000_1010; cfg_len = 4'd4;
      step(1'b1, 1'b0, 1'b0, "rstmid_edge");
      step(1'b1, 1'b0, 1'b0, "rstmid_post");
`ifdef SEQDET_COUNT_EN
      check("rstmid_cnt", {28'd0, match_cnt}, 32'd0);
`endif
      send6(6'b111010, 6'b000001, "rst_default");

      // Load with x_valid: bit discarded, so the first new bit alone can't match
      cfg_load = 1'b1; cfg_pattern = 8'b0000_0011; cfg_len = 4'd2;
      step(1'b1, 1'b1, 1'b0, "ldv_edge");
      step(1'b1, 1'b1, 1'b0, "ldv_b1");
      step(1'b1, 1'b1, 1'b1, "ldv_b2");
      step(1'b1, 1'b1, 1'b1, "b2b_b3");
      step(1'b1, 1'b0, 1'b0, "ldv_b4");

      // Counter clear coinciding with a match
      step(1'b1, 1'b1, 1'b0, "clr_b1");
      cnt_clr = 1'b1;
      step(1'b1, 1'b1, 1'b1, "clr_match");
`ifdef SEQDET_COUNT_EN
      check("clr_match_cnt", {28'd0, match_cnt}, 32'd1);
`endif

      // Length 0 disables detection even with an all-zero pattern
      load(8'h00, 4'd0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "len0");

      // Length 12 clamps to 8
      load(8'b1100_1010, 4'd12, 1'b0);
      send6(6'b110010, 6'b000000, "clamp_a");
      step(1'b1, 1'b1, 1'b0, "clamp_b7");
      step(1'b1, 1'b0, 1'b1, "clamp_b8");

`ifdef SEQDET_COUNT_EN
      // Saturation: 20 matches on a 4-bit counter
      load(8'b0000_0011, 4'd2, 1'b1);
      for (int i = 0; i < 21; i++) step(1'b1, 1'b1, (i > 0), "sat_y");
      check("sat_cnt", {28'd0, match_cnt}, 32'd15);
      cnt_clr = 1'b1;
      step(1'b0, 1'b0, 1'b0, "satclr_y");
      check("satclr_cnt", {28'd0, match_cnt}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
